instr_sequencer: RTL and testbench

Multicycle fetch/execute controller that sits directly downstream of the 32×16 instruction memory. It owns the program counter and drives the instruction-memory read address. It latches each returned instruction word, decodes it, and issues the register-file, data-memory and branch control for that instruction. The two-state fetch/execute loop runs until a stop opcode halts the core.

---
 rtl/instr_sequencer_if.sv | 27 ++
 rtl/instr_sequencer.sv | 116 +++++++++++
 tb/tb_instr_sequencer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Bus bundle between the sequencer and its instruction memory, register file and data memory.
// master = sequencer side, slave = memory/register-file side.
interface instr_sequencer_if;
  logic [4:0]  im_addr;
  logic [15:0] im_data;
  logic [3:0]  rf_ra1;
  logic [3:0]  rf_ra2;
  logic [15:0] rf_rd1;
  logic [15:0] rf_rd2;
  logic [3:0]  rf_wa;
  logic [15:0] rf_wd;
  logic        rf_we;
  logic [3:0]  dm_addr;
  logic [15:0] dm_wd;
  logic        dm_we;
  logic [15:0] dm_rd;

  modport master (
    output im_addr, rf_ra1, rf_ra2, rf_wa, rf_wd, rf_we, dm_addr, dm_wd, dm_we,
    input  im_data, rf_rd1, rf_rd2, dm_rd
  );

  modport slave (
    input  im_addr, rf_ra1, rf_ra2, rf_wa, rf_wd, rf_we, dm_addr, dm_wd, dm_we,
    output im_data, rf_rd1, rf_rd2, dm_rd
  );
endinterface

// File: rtl/instr_sequencer.sv
// Two-cycle fetch/execute controller: owns the pc, latches the fetched word and
// decodes it into register-file, data-memory and branch control until a stop opcode.
module instr_sequencer (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  instr_sequencer_if.master      bus,
  output logic [4:0]             pc,
  output logic                   halted,
  output logic [15:0]            retired
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  localparam logic [2:0] OP_STORE = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_BEQ   = 3'b101;
  localparam logic [2:0] OP_STOP  = 3'b111;

  state_t      state;
  logic [15:0] ir;
  logic [2:0]  op;
  logic        operands_equal;

  assign op             = ir[15:13];
  assign operands_equal = (bus.rf_rd1 == bus.rf_rd2);
  assign bus.im_addr    = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= 5'd0;
      ir      <= 16'h0000;
      retired <= 16'h0000;
      halted  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start)
            state <= FETCH;
        end
        FETCH: begin
          ir    <= bus.im_data;
          state <= EXEC;
        end
        EXEC: begin
          if (retired != 16'hFFFF)
            retired <= retired + 16'd1;
          // stop keeps pc at its own address so the halted core points at it
          if (op == OP_STOP) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state <= FETCH;
            if (op == OP_BEQ && operands_equal)
              pc <= ir[12:8];
            else
              pc <= pc + 5'd1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decode is purely from ir and gated by EXEC, so an async reset drops the enables at once.
  always_comb begin
    bus.rf_ra1  = 4'd0;
    bus.rf_ra2  = 4'd0;
    bus.rf_wa   = 4'd0;
    bus.rf_wd   = 16'h0000;
    bus.rf_we   = 1'b0;
    bus.dm_addr = 4'd0;
    bus.dm_wd   = 16'h0000;
    bus.dm_we   = 1'b0;
    if (state == EXEC) begin
      case (op)
        OP_STORE: begin
          bus.dm_addr = ir[7:4];
          bus.rf_ra1  = ir[3:0];
          bus.dm_wd   = bus.rf_rd1;
          bus.dm_we   = 1'b1;
        end
        OP_LOAD: begin
          if (ir[12]) begin
            bus.rf_wa = ir[11:8];
            bus.rf_wd = {8'h00, ir[7:0]};
          end else begin
            bus.dm_addr = ir[7:4];
            bus.rf_wa   = ir[3:0];
            bus.rf_wd   = bus.dm_rd;
          end
          bus.rf_we = 1'b1;
        end
        OP_ADD: begin
          bus.rf_wa  = ir[11:8];
          bus.rf_ra1 = ir[7:4];
          bus.rf_ra2 = ir[3:0];
          bus.rf_wd  = bus.rf_rd1 + bus.rf_rd2;
          bus.rf_we  = 1'b1;
        end
        OP_BEQ: begin
          bus.rf_ra1 = ir[7:4];
          bus.rf_ra2 = ir[3:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: behavioural memories around the DUT and an
// instruction-level interpreter as reference for directed and random programs.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  pc;
  logic        halted;
  logic [15:0] retired;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (bus),
    .pc      (pc),
    .halted  (halted),
    .retired (retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] imem [32];
  logic [15:0] rf   [16];
  logic [15:0] dm   [16];

  assign bus.im_data = imem[bus.im_addr];
  assign bus.rf_rd1  = rf[bus.rf_ra1];
  assign bus.rf_rd2  = rf[bus.rf_ra2];
  assign bus.dm_rd   = dm[bus.dm_addr];

  int          dm_writes = 0;
  int          cyc = 0;
  logic [15:0] last_dm_wd = 16'h0;
  logic [3:0]  last_dm_addr = 4'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rf_we)
      rf[bus.rf_wa] <= bus.rf_wd;
    if (bus.dm_we) begin
      dm[bus.dm_addr] <= bus.dm_wd;
      dm_writes       <= dm_writes + 1;
      last_dm_wd      <= bus.dm_wd;
      last_dm_addr    <= bus.dm_addr;
    end
  end

  // Record every pc change so jumps can be recovered from the trace afterwards.
  logic [4:0] pc_hist [$];
  logic [4:0] hist_last = 5'd0;
  always @(negedge clk) begin
    if (pc !== hist_last) begin
      pc_hist.push_back(pc);
      hist_last <= pc;
    end
  end

  int hist_base;
  int dm_base;
  int t0;

  // Reference model state: an instruction-at-a-time interpreter of the ISA.
  logic [15:0] m_im [32];
  logic [15:0] m_rf [16];
  logic [15:0] m_dm [16];
  logic [4:0]  m_pc;
  int          m_exec;
  int          m_dmw;

  task automatic model_run();
    int          p;
    logic [15:0] w;
    bit          done;
    p = 0; done = 0; m_exec = 0; m_dmw = 0;
    while (!done && m_exec < 2000) begin
      w = m_im[p];
      m_exec++;
      case (w[15:13])
        3'b000: begin m_dm[w[7:4]] = m_rf[w[3:0]]; m_dmw++; p = (p + 1) % 32; end
        3'b001: begin
          if (w[12]) m_rf[w[11:8]] = {8'h00, w[7:0]};
          else       m_rf[w[3:0]]  = m_dm[w[7:4]];
          p = (p + 1) % 32;
        end
        3'b010: begin
          m_rf[w[11:8]] = 16'((int'(m_rf[w[7:4]]) + int'(m_rf[w[3:0]])) % 65536);
          p = (p + 1) % 32;
        end
        3'b101: p = (m_rf[w[7:4]] == m_rf[w[3:0]]) ? int'(w[12:8]) : (p + 1) % 32;
        3'b111: done = 1;
        default: p = (p + 1) % 32;
      endcase
    end
    m_pc = 5'(p);
  endtask

  // Hold reset, load memories, release and take baselines for the trace and write counters.
  task automatic begin_test(input logic [15:0] prog [32], input logic [15:0] rf0 [16],
                            input logic [15:0] dm0 [16]);
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 32; i++) imem[i] = prog[i];
    for (int i = 0; i < 16; i++) begin
      rf[i] <= rf0[i];
      dm[i] <= dm0[i];
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    hist_base = pc_hist.size();
    dm_base   = dm_writes;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int cycles);
    while (!halted && (cyc - t0) < budget) begin
      @(posedge clk);
      #1;
    end
    cycles = cyc - t0;
  endtask

  logic [15:0] prog [32];
  logic [15:0] rf0  [16];
  logic [15:0] dm0  [16];

  task automatic clear_images();
    for (int i = 0; i < 32; i++) prog[i] = 16'hE000;
    for (int i = 0; i < 16; i++) begin rf0[i] = 16'h0; dm0[i] = 16'h0; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({pc, halted, retired, bus.im_addr, bus.rf_we, bus.dm_we, bus.rf_ra1, bus.rf_ra2,
         bus.rf_wa, bus.rf_wd, bus.dm_addr, bus.dm_wd} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: pc=%0d halted=%b retired=%0d rf_we=%b dm_we=%b, required all zero",
               pc, halted, retired, bus.rf_we, bus.dm_we);
    end
    clear_images();
    begin_test(prog, rf0, dm0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (pc !== 5'd0 || bus.im_addr !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL idle_pc: pc=%0d im_addr=%0d, required 0", pc, bus.im_addr);
    end
    n_checks++;
    if (bus.rf_we !== 1'b0 || bus.dm_we !== 1'b0 || retired !== 16'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_quiet: rf_we=%b dm_we=%b retired=%0d halted=%b, required 0 0 0 0",
               bus.rf_we, bus.dm_we, retired, halted);
    end
  endtask

  task automatic test_load_store();
    int cycles;
    clear_images();
    prog[0] = 16'h3004;
    prog[1] = 16'h0010;
    prog[2] = 16'hE000;
    begin_test(prog, rf0, dm0);
    applyStimulus();
    @(negedge clk);
    n_checks++;
    if (bus.rf_we !== 1'b0 || bus.dm_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fetch_quiet: rf_we=%b dm_we=%b, required 0 0", bus.rf_we, bus.dm_we);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 4'd0, 16'd4}) begin
      n_fail++;
      $display("[TB] FAIL li_exec: rf_we=%b rf_wa=%0d rf_wd=%h, required 1 0 0004",
               bus.rf_we, bus.rf_wa, bus.rf_wd);
    end
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({bus.dm_we, bus.dm_addr, bus.dm_wd} !== {1'b1, 4'd1, 16'd4}) begin
      n_fail++;
      $display("[TB] FAIL st_exec: dm_we=%b dm_addr=%0d dm_wd=%h, required 1 1 0004",
               bus.dm_we, bus.dm_addr, bus.dm_wd);
    end
    run_to_halt(50, cycles);
    n_checks++;
    if (cycles !== 6 || halted !== 1'b1 || retired !== 16'd3 || pc !== 5'd2) begin
      n_fail++;
      $display("[TB] FAIL li_st_halt: cycles=%0d halted=%b retired=%0d pc=%0d, required 6 1 3 2",
               cycles, halted, retired, pc);
    end
    // start held high after halting must not relaunch
    start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (halted !== 1'b1 || retired !== 16'd3 || pc !== 5'd2 || dm[1] !== 16'd4) begin
      n_fail++;
      $display("[TB] FAIL halt_sticky: halted=%b retired=%0d pc=%0d dm1=%h, required 1 3 2 0004",
               halted, retired, pc, dm[1]);
    end
  endtask

  task automatic test_add_wrap();
    int cycles;
    clear_images();
    rf0[1] = 16'hFFFF;
    rf0[2] = 16'h0002;
    prog[0] = 16'h4312;
    begin_test(prog, rf0, dm0);
    applyStimulus();
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 4'd3, 16'h0001}) begin
      n_fail++;
      $display("[TB] FAIL add_wrap: rf_we=%b rf_wa=%0d rf_wd=%h, required 1 3 0001",
               bus.rf_we, bus.rf_wa, bus.rf_wd);
    end
    run_to_halt(50, cycles);
    n_checks++;
    if (rf[3] !== 16'h0001 || cycles !== 4) begin
      n_fail++;
      $display("[TB] FAIL add_commit: rf3=%h cycles=%0d, required 0001 4", rf[3], cycles);
    end
  endtask

  task automatic test_multiply();
    int cycles;
    int back13;
    int fwd17;
    logic [4:0] prev;
    clear_images();
    prog[0]  = 16'h3004; prog[1]  = 16'h3105; prog[2]  = 16'h0000; prog[3]  = 16'h0011;
    prog[4]  = 16'h2000; prog[5]  = 16'h2011; prog[6]  = 16'h3200; prog[7]  = 16'h3F00;
    prog[8]  = 16'h3301; prog[9]  = 16'h3400; prog[10] = 16'h6000; prog[11] = 16'h8000;
    prog[12] = 16'hC000; prog[13] = 16'hB121; prog[14] = 16'h4FF0; prog[15] = 16'h4223;
    prog[16] = 16'hAD44; prog[17] = 16'h003F; prog[18] = 16'hE000;
    begin_test(prog, rf0, dm0);
    applyStimulus();
    run_to_halt(500, cycles);
    @(negedge clk);
    back13 = 0; fwd17 = 0; prev = 5'd0;
    for (int i = hist_base; i < pc_hist.size(); i++) begin
      if (pc_hist[i] !== prev + 5'd1) begin
        if (pc_hist[i] == 5'd13) back13++;
        if (pc_hist[i] == 5'd17) fwd17++;
      end
      prev = pc_hist[i];
    end
    n_checks++;
    if (dm[3] !== 16'h0014 || last_dm_addr !== 4'd3 || last_dm_wd !== 16'h0014) begin
      n_fail++;
      $display("[TB] FAIL mul_result: dm3=%h last_write=%h@%0d, required 0014@3",
               dm[3], last_dm_wd, last_dm_addr);
    end
    n_checks++;
    if (halted !== 1'b1 || pc !== 5'd18 || retired !== 16'd36 || cycles !== 72) begin
      n_fail++;
      $display("[TB] FAIL mul_halt: halted=%b pc=%0d retired=%0d cycles=%0d, required 1 18 36 72",
               halted, pc, retired, cycles);
    end
    n_checks++;
    if (back13 !== 5 || fwd17 !== 1) begin
      n_fail++;
      $display("[TB] FAIL mul_branches: back13=%0d fwd17=%0d, required 5 1", back13, fwd17);
    end
  endtask

  task automatic test_branch_wrap();
    int cycles;
    int after31;
    clear_images();
    rf0[1] = 16'd1;
    rf0[2] = 16'd2;
    prog[0]  = 16'hBE56;
    prog[30] = 16'h3501;
    prog[31] = 16'hA512;
    begin_test(prog, rf0, dm0);
    applyStimulus();
    run_to_halt(100, cycles);
    @(negedge clk);
    after31 = -1;
    for (int i = hist_base; i + 1 < pc_hist.size(); i++)
      if (pc_hist[i] == 5'd31 && after31 < 0) after31 = int'(pc_hist[i + 1]);
    n_checks++;
    if (after31 !== 0) begin
      n_fail++;
      $display("[TB] FAIL beq_wrap: pc after 31 = %0d, required 0", after31);
    end
    n_checks++;
    if (pc !== 5'd1 || retired !== 16'd5 || cycles !== 10 || halted !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL beq_wrap_end: pc=%0d retired=%0d cycles=%0d halted=%b, required 1 5 10 1",
               pc, retired, cycles, halted);
    end
  endtask

  task automatic test_reset_mid_exec();
    clear_images();
    rf0[1] = 16'hABCD;
    prog[0] = 16'h0021;
    begin_test(prog, rf0, dm0);
    applyStimulus();
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({bus.dm_we, bus.dm_addr, bus.dm_wd} !== {1'b1, 4'd2, 16'hABCD}) begin
      n_fail++;
      $display("[TB] FAIL st_before_reset: dm_we=%b dm_addr=%0d dm_wd=%h, required 1 2 abcd",
               bus.dm_we, bus.dm_addr, bus.dm_wd);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.dm_we !== 1'b0 || bus.rf_we !== 1'b0 || pc !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_drop: dm_we=%b rf_we=%b pc=%0d, required 0 0 0",
               bus.dm_we, bus.rf_we, pc);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (dm_writes !== dm_base || dm[2] !== 16'h0000 || pc !== 5'd0 || halted !== 1'b0 ||
        retired !== 16'd0 || bus.dm_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_no_write: writes=%0d dm2=%h pc=%0d halted=%b retired=%0d, required %0d 0000 0 0 0",
               dm_writes - dm_base, dm[2], pc, halted, retired, 0);
    end
  endtask

  function automatic logic [15:0] rand_instr(input int idx, input int last);
    logic [3:0] ra;
    case ($urandom_range(0, 5))
      0: return {3'b001, 1'b1, 4'($urandom), 8'($urandom)};
      1: return {3'b001, 1'b0, 12'($urandom)};
      2: return {3'b000, 13'($urandom)};
      3: return {3'b010, 13'($urandom)};
      4: begin
        case ($urandom_range(0, 2))
          0: return {3'b011, 13'($urandom)};
          1: return {3'b100, 13'($urandom)};
          default: return {3'b110, 13'($urandom)};
        endcase
      end
      default: begin
        ra = 4'($urandom);
        return {3'b101, 5'($urandom_range(idx + 1, last)), ra,
                ($urandom_range(0, 1) == 1) ? ra : 4'($urandom)};
      end
    endcase
  endfunction

  task automatic test_random();
    int cycles;
    int len;
    for (int iter = 0; iter < 20; iter++) begin
      clear_images();
      len = $urandom_range(2, 24);
      for (int i = 0; i < len - 1; i++) prog[i] = rand_instr(i, len - 1);
      prog[len - 1] = {3'b111, 13'($urandom)};
      for (int i = 0; i < 16; i++) begin
        rf0[i] = 16'($urandom);
        dm0[i] = 16'($urandom);
      end
      for (int i = 0; i < 32; i++) m_im[i] = prog[i];
      for (int i = 0; i < 16; i++) begin m_rf[i] = rf0[i]; m_dm[i] = dm0[i]; end
      model_run();
      begin_test(prog, rf0, dm0);
      applyStimulus();
      run_to_halt(200, cycles);
      @(negedge clk);
      n_checks++;
      if (halted !== 1'b1 || cycles !== 2 * m_exec || retired !== 16'(m_exec) || pc !== m_pc) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_flow: halted=%b cycles=%0d retired=%0d pc=%0d, required 1 %0d %0d %0d",
                 iter, halted, cycles, retired, pc, 2 * m_exec, m_exec, m_pc);
      end
      n_checks++;
      if (dm_writes - dm_base !== m_dmw) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_dm_writes: got %0d, required %0d", iter, dm_writes - dm_base, m_dmw);
      end
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (rf[i] !== m_rf[i] || dm[i] !== m_dm[i]) begin
          n_fail++;
          $display("[TB] FAIL rand%0d_state[%0d]: rf=%h dm=%h, required rf=%h dm=%h",
                   iter, i, rf[i], dm[i], m_rf[i], m_dm[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_add_wrap();
    test_multiply();
    test_branch_wrap();
    test_reset_mid_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
